// File: rtl/pulse_pkg.sv
// Shared types for the pulse period meter: FSM state encoding.
package pulse_pkg;

   typedef enum logic {
      S_ARMED,
      S_MEASURING
   } meter_state_t;

endpackage

// File: rtl/min_max_tracker.sv
// Tracks the smallest and largest measured period since reset or clear,
// plus whether a reference sample exists for the stability compare.
module min_max_tracker #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         sample_valid,
   input  logic [N-1:0] sample,
   output logic [N-1:0] min_period,
   output logic [N-1:0] max_period,
   output logic         has_ref
);

   // A sample coinciding with clear is not folded into min/max, but it still
   // serves as the reference for the next stability compare.
   always_ff @(posedge clk) begin
      if (rst) begin
         min_period <= '1;
         max_period <= '0;
         has_ref    <= 1'b0;
      end else if (clear) begin
         min_period <= '1;
         max_period <= '0;
         has_ref    <= sample_valid;
      end else if (sample_valid) begin
         if (sample < min_period) min_period <= sample;
         if (sample > max_period) max_period <= sample;
         has_ref <= 1'b1;
      end
   end

endmodule

// File: rtl/pulse_period_meter.sv
// Measures the number of enabled cycles between successive strobes on in,
// reporting each period with a valid pulse and timing out when strobes stop.
module pulse_period_meter
   import pulse_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ena,
   input  logic         clear,
   input  logic         in,
   output logic [N-1:0] period,
   output logic         valid,
   output logic         timeout,
   output logic [N-1:0] min_period,
   output logic [N-1:0] max_period,
   output logic         stable
);

   meter_state_t state;
   logic [N-1:0] count;
   logic         ev;
   logic         measure;
   logic         expire;
   logic         has_ref;

   assign ev      = ena & in;
   assign measure = (state == S_MEASURING) && ev;
   assign expire  = ena && (state == S_MEASURING) && !in && (count == '1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_ARMED;
         count   <= '0;
         period  <= '0;
         valid   <= 1'b0;
         timeout <= 1'b0;
         stable  <= 1'b0;
      end else begin
         valid   <= 1'b0;
         timeout <= 1'b0;
         if (ena) begin
            case (state)
               S_ARMED: begin
                  if (ev) begin
                     count <= 1;
                     state <= S_MEASURING;
                  end
               end
               S_MEASURING: begin
                  if (ev) begin
                     period <= count;
                     valid  <= 1'b1;
                     count  <= 1;
                  end else if (count == '1) begin
                     timeout <= 1'b1;
                     state   <= S_ARMED;
                     count   <= '0;
                  end else begin
                     count <= count + 1'b1;
                  end
               end
               default: begin
                  state <= S_ARMED;
                  count <= '0;
               end
            endcase
         end
         // The compare uses the previous period, before this cycle's update lands.
         if (clear) begin
            stable <= 1'b0;
         end else if (measure) begin
            stable <= has_ref && (count == period);
         end else if (expire) begin
            stable <= 1'b0;
         end
      end
   end

   min_max_tracker #(.N(N)) u_tracker (
      .clk          (clk),
      .rst          (rst),
      .clear        (clear),
      .sample_valid (measure),
      .sample       (count),
      .min_period   (min_period),
      .max_period   (max_period),
      .has_ref      (has_ref)
   );

endmodule

// File: tb/tb_pulse_period_meter.sv
// Self-checking bench for pulse_period_meter: directed scenarios plus random
// traffic, all compared against an event-index reference model.
module tb_pulse_period_meter;

   localparam int N    = 8;
   localparam int MAXC = (1 << N) - 1;

   logic clk = 1'b0;
   logic rst, ena, clear, in;
   logic [N-1:0] period, min_period, max_period;
   logic valid, timeout, stable;

   int checks = 0;
   int errors = 0;

   // Reference model: enabled cycles are numbered, and a period is the
   // difference between the indices of two consecutive events.
   int ecount;
   int ref_idx;
   logic [N-1:0] m_period, m_min, m_max;
   logic m_valid, m_timeout, m_stable, m_has_ref;

   pulse_period_meter #(.N(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .ena        (ena),
      .clear      (clear),
      .in         (in),
      .period     (period),
      .valid      (valid),
      .timeout    (timeout),
      .min_period (min_period),
      .max_period (max_period),
      .stable     (stable)
   );

   always #5 clk = ~clk;

   task automatic step(input logic s_in, input logic s_ena, input logic s_clear, input logic s_rst);
      int   gap;
      logic meas;
      in    = s_in;
      ena   = s_ena;
      clear = s_clear;
      rst   = s_rst;
      @(posedge clk);
      gap       = 0;
      meas      = 1'b0;
      m_valid   = 1'b0;
      m_timeout = 1'b0;
      if (s_rst) begin
         ecount    = 0;
         ref_idx   = -1;
         m_period  = '0;
         m_min     = '1;
         m_max     = '0;
         m_stable  = 1'b0;
         m_has_ref = 1'b0;
      end else begin
         if (s_ena) begin
            ecount++;
            if (s_in) begin
               if (ref_idx >= 0) begin
                  gap  = ecount - ref_idx;
                  meas = 1'b1;
               end
               ref_idx = ecount;
            end else if (ref_idx >= 0 && ecount - ref_idx == MAXC) begin
               m_timeout = 1'b1;
               ref_idx   = -1;
            end
         end
         if (s_clear) begin
            m_min     = '1;
            m_max     = '0;
            m_stable  = 1'b0;
            m_has_ref = meas;
         end else if (meas) begin
            m_stable = m_has_ref && (gap == int'(m_period));
            if (gap < int'(m_min)) m_min = gap[N-1:0];
            if (gap > int'(m_max)) m_max = gap[N-1:0];
            m_has_ref = 1'b1;
         end else if (m_timeout) begin
            m_stable = 1'b0;
         end
         if (meas) begin
            m_period = gap[N-1:0];
            m_valid  = 1'b1;
         end
      end
      #1;
   endtask

   task automatic strobe_after(input int gap, input logic clr);
      for (int i = 1; i < gap; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, clr, 1'b0);
   endtask

   task automatic test_reset;
      logic seen = 1'b0;
      step(1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      checks++;
      if ({period, valid, timeout, min_period, max_period, stable} !== {8'd0, 1'b0, 1'b0, 8'hff, 8'd0, 1'b0}) begin
         errors++;
         $display("[TB] FAIL reset_values: got %h want %h",
                  {period, valid, timeout, min_period, max_period, stable},
                  {8'd0, 1'b0, 1'b0, 8'hff, 8'd0, 1'b0});
      end
      for (int c = 0; c < 300; c++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0);
         if (timeout !== 1'b0 || valid !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("[TB] FAIL idle_no_activity: got activity=%b want 0", seen);
      end
   endtask

   task automatic test_periodic;
      int nvalid = 0;
      int first  = -1;
      step(1'b0, 1'b1, 1'b0, 1'b1);
      for (int c = 0; c < 30; c++) begin
         step((c % 5) == 0, 1'b1, 1'b0, 1'b0);
         if (valid === 1'b1) begin
            nvalid++;
            if (first < 0) first = c;
         end
         checks++;
         if ({period, valid, timeout, min_period, max_period, stable} !== {m_period, m_valid, m_timeout, m_min, m_max, m_stable}) begin
            errors++;
            $display("[TB] FAIL periodic c=%0d: got %h want %h", c,
                     {period, valid, timeout, min_period, max_period, stable},
                     {m_period, m_valid, m_timeout, m_min, m_max, m_stable});
         end
         if (c >= 10) begin
            checks++;
            if (stable !== 1'b1) begin
               errors++;
               $display("[TB] FAIL periodic_stable c=%0d: got %b want 1", c, stable);
            end
         end
      end
      checks++;
      if (first !== 5 || nvalid !== 5) begin
         errors++;
         $display("[TB] FAIL periodic_valids: got first=%0d count=%0d want first=5 count=5", first, nvalid);
      end
      checks++;
      if ({period, min_period, max_period} !== {8'd5, 8'd5, 8'd5}) begin
         errors++;
         $display("[TB] FAIL periodic_minmax: got p=%0d min=%0d max=%0d want 5 5 5", period, min_period, max_period);
      end
   endtask

   task automatic test_boundaries;
      int nvalid = 0;
      int ntime  = 0;
      int t_at   = -1;
      step(1'b0, 1'b1, 1'b0, 1'b1);
      for (int c = 0; c < 5; c++) begin
         step(1'b1, 1'b1, 1'b0, 1'b0);
         if (c > 0) begin
            checks++;
            if (valid !== 1'b1 || period !== 8'd1) begin
               errors++;
               $display("[TB] FAIL consecutive c=%0d: got v=%b p=%0d want v=1 p=1", c, valid, period);
            end
         end
      end
      step(1'b0, 1'b1, 1'b0, 1'b1);
      for (int c = 0; c <= 255; c++) begin
         step(c == 0 || c == 255, 1'b1, 1'b0, 1'b0);
         if (timeout === 1'b1) ntime++;
         if (valid === 1'b1) nvalid++;
      end
      checks++;
      if (ntime !== 0 || nvalid !== 1 || period !== 8'd255) begin
         errors++;
         $display("[TB] FAIL gap255: got timeouts=%0d valids=%0d p=%0d want 0 1 255", ntime, nvalid, period);
      end
      step(1'b0, 1'b1, 1'b0, 1'b1);
      ntime  = 0;
      nvalid = 0;
      for (int c = 0; c <= 256; c++) begin
         step(c == 0 || c == 256, 1'b1, 1'b0, 1'b0);
         if (timeout === 1'b1) begin
            ntime++;
            t_at = c;
         end
         if (valid === 1'b1) nvalid++;
      end
      checks++;
      if (ntime !== 1 || t_at !== 255 || nvalid !== 0) begin
         errors++;
         $display("[TB] FAIL gap256: got timeouts=%0d at=%0d valids=%0d want 1 255 0", ntime, t_at, nvalid);
      end
      strobe_after(3, 1'b0);
      checks++;
      if (valid !== 1'b1 || period !== 8'd3) begin
         errors++;
         $display("[TB] FAIL after_timeout: got v=%b p=%0d want v=1 p=3", valid, period);
      end
   endtask

   task automatic test_ena_gating;
      logic en_pat [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic in_pat [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      step(1'b0, 1'b1, 1'b0, 1'b1);
      for (int c = 0; c < 8; c++) begin
         step(in_pat[c], en_pat[c], 1'b0, 1'b0);
         checks++;
         if ({period, valid, timeout, min_period, max_period, stable} !== {m_period, m_valid, m_timeout, m_min, m_max, m_stable}) begin
            errors++;
            $display("[TB] FAIL ena_gating c=%0d: got %h want %h", c,
                     {period, valid, timeout, min_period, max_period, stable},
                     {m_period, m_valid, m_timeout, m_min, m_max, m_stable});
         end
      end
      checks++;
      if (valid !== 1'b1 || period !== 8'd4) begin
         errors++;
         $display("[TB] FAIL ena_period: got v=%b p=%0d want v=1 p=4", valid, period);
      end
   endtask

   task automatic test_minmax_clear;
      step(1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      strobe_after(7, 1'b0);
      strobe_after(3, 1'b0);
      strobe_after(9, 1'b0);
      checks++;
      if ({period, min_period, max_period, stable} !== {8'd9, 8'd3, 8'd9, 1'b0}) begin
         errors++;
         $display("[TB] FAIL minmax_739: got p=%0d min=%0d max=%0d s=%b want 9 3 9 0", period, min_period, max_period, stable);
      end
      strobe_after(6, 1'b1);
      checks++;
      if ({valid, period, min_period, max_period, stable} !== {1'b1, 8'd6, 8'hff, 8'd0, 1'b0}) begin
         errors++;
         $display("[TB] FAIL clear_coincident: got v=%b p=%0d min=%0d max=%0d s=%b want 1 6 255 0 0", valid, period, min_period, max_period, stable);
      end
      strobe_after(6, 1'b0);
      checks++;
      if ({period, min_period, max_period, stable} !== {8'd6, 8'd6, 8'd6, 1'b1}) begin
         errors++;
         $display("[TB] FAIL after_clear: got p=%0d min=%0d max=%0d s=%b want 6 6 6 1", period, min_period, max_period, stable);
      end
   endtask

   task automatic test_reset_mid;
      int nvalid = 0;
      step(1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      for (int c = 0; c < 10; c++) step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      for (int c = 0; c < 13; c++) begin
         step(c == 4 || c == 12, 1'b1, 1'b0, 1'b0);
         if (valid === 1'b1) nvalid++;
      end
      checks++;
      if (nvalid !== 1 || period !== 8'd8) begin
         errors++;
         $display("[TB] FAIL reset_mid: got valids=%0d p=%0d want 1 8", nvalid, period);
      end
   endtask

   task automatic test_random;
      int sel;
      logic r_in;
      step(1'b0, 1'b1, 1'b0, 1'b1);
      for (int blk = 0; blk < 8; blk++) begin
         sel = $urandom_range(0, 2);
         for (int c = 0; c < 400; c++) begin
            case (sel)
               0:       r_in = ($urandom % 2) == 0;
               1:       r_in = ($urandom % 8) == 0;
               default: r_in = ($urandom % 300) == 0;
            endcase
            step(r_in, ($urandom % 6) != 0, ($urandom % 80) == 0, ($urandom % 700) == 0);
            checks++;
            if ({period, valid, timeout, min_period, max_period, stable} !== {m_period, m_valid, m_timeout, m_min, m_max, m_stable}) begin
               errors++;
               $display("[TB] FAIL random blk=%0d c=%0d: got %h want %h", blk, c,
                        {period, valid, timeout, min_period, max_period, stable},
                        {m_period, m_valid, m_timeout, m_min, m_max, m_stable});
            end
         end
      end
   endtask

   initial begin
      rst   = 1'b1;
      ena   = 1'b0;
      clear = 1'b0;
      in    = 1'b0;
      test_reset();
      test_periodic();
      test_boundaries();
      test_ena_gating();
      test_minmax_clear();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pulse_period_meter.md
# pulse_period_meter

Measures the interval, in clock cycles, between successive single-cycle strobes on `in`. It is the receiving end of the periodic strobe trains produced elsewhere in the etch-a-sketch datapath. It reports each measured period with a one-cycle valid strobe, tracks minimum and maximum period, flags stability, and times out when strobes stop. It is used to check and calibrate strobe sources, such as a generator programmed with `ticks`, where it must read back exactly `ticks`.

## Interface
- `N`, default 8: width of period counter and all period outputs.
- `clk` input, 1 bit: clock.
- `rst` input, 1 bit: reset, synchronous, active-high.
- `ena` input, 1 bit: count enable. When low, the counter holds and strobes on `in` are ignored.
- `clear` input, 1 bit: synchronous clear of `min_period`, `max_period` and `stable` only.
- `in` input, 1 bit: event strobe. Each cycle with `in & ena` high is one event.
- `period` output, N bits: last measured period in cycles.
- `valid` output, 1 bit: one-cycle pulse; `period` was updated this cycle.
- `timeout` output, 1 bit: one-cycle pulse; counter saturated with no event.
- `min_period` output, N bits: smallest period since reset or clear.
- `max_period` output, N bits: largest period since reset or clear.
- `stable` output, 1 bit: high while the last two measured periods are equal.

## Operation
- Event: `ev = ena & in`. All outputs are registered.
- The FSM has two states: `S_ARMED` (no reference event yet) and `S_MEASURING`.
- `S_ARMED`:
  - On `ev`: counter ← 1, go to `S_MEASURING`.
  - No output activity in this state.
- `S_MEASURING`, each cycle with `ena` high:
  - If `ev`: `period` ← counter, `valid` ← 1, counter ← 1, stay in `S_MEASURING`.
  - Else if counter == 2^N−1: `timeout` ← 1, go to `S_ARMED`, counter ← 0.
  - Else: counter ← counter+1.
- `ena` low: counter, state and all registers hold. `valid` and `timeout` are 0.
- Period arithmetic: events at cycles j and k (with `ena` high throughout) give `period` = k−j. Legal range is 1 to 2^N−1. An event arriving in the same cycle that counter == 2^N−1 is a valid measurement, not a timeout.
- Min/max update, on each measurement:
  - `min_period` ← min(`min_period`, new).
  - `max_period` ← max(`max_period`, new).
- Stable update:
  - `stable` ← (new == `period`) on the second and later measurements after reset or clear.
  - The first measurement after reset or clear sets `stable` ← 0.
  - Timeout clears `stable`.
- Clear:
  - `min_period` ← all-ones, `max_period` ← 0, `stable` ← 0, and the "first measurement" flag is re-armed.
  - If `clear` coincides with a measurement, `clear` wins for min/max/stable. `period` and `valid` still update. That sample is not folded into min/max but becomes the reference for the next `stable` compare.

## Timing
- Reset values:
  - state `S_ARMED`, counter 0.
  - `period` 0, `valid` 0, `timeout` 0.
  - `min_period` all-ones, `max_period` 0, `stable` 0.
- Latency: `valid`, `period`, `min_period`, `max_period` and `stable` all change on the clock edge after the cycle containing the second (or later) event.
- `valid` is never high for two consecutive cycles unless events occur in consecutive cycles (period 1).
- `timeout` fires in the cycle after counter == 2^N−1 with no event. That is 2^N−1 enabled cycles after the last event.
- Reset mid-measurement: the partial count is discarded and the first event after reset is only a reference.
- Priority: `rst` > `clear` > measurement update.

## Structure
- Shared package `pulse_pkg`:
  - `meter_state_t` enum {`S_ARMED`, `S_MEASURING`}.
  - No width constants; `N` remains a parameter.
- One sub-module: `min_max_tracker`, parameterised by N. Inputs are `clk`, `rst`, `clear`, `sample_valid` and `sample[N-1:0]`. It owns `min_period`, `max_period` and the first-sample flag.
- FSM, counter and `stable` compare live in `pulse_period_meter`.

## Test plan
- Reset then idle: hold `rst` 2 cycles with `in` = 0 for 300 cycles → all outputs at reset values, `timeout` never fires (state `S_ARMED`).
- Periodic train: N=8, strobe every 5 cycles, `ena` = 1.
  - First `valid` one cycle after the 2nd strobe, with `period` = 5.
  - `valid` repeats every 5 cycles.
  - `min_period` = `max_period` = 5.
  - `stable` = 1 from the 3rd strobe on.
- Boundaries:
  - Strobes in consecutive cycles → `period` = 1, `valid` high continuously.
  - Strobes 255 cycles apart → `period` = 255, no `timeout`.
  - Strobes 256 apart → `timeout` pulse 255 cycles after the first strobe, no `valid`. The next strobe is a reference only.
- `ena` gating: strobes 4 cycles apart with `ena` low for 3 cycles in between (strobes during low `ena` dropped) → `period` = 4 + 0 counted low cycles, i.e. counts only enabled cycles.
- Min/max and clear:
  - Periods 7, 3, 9 → min 3, max 9, `stable` 0.
  - Assert `clear` coincident with a period-6 measurement → `period` = 6, min all-ones, max 0.
  - Next period 6 → min 6, max 6, `stable` 1.
- Reset mid-measurement: strobe, 10 cycles, `rst` pulse, strobe 5 cycles later, strobe 8 cycles after that → only one `valid`, with `period` = 8.
